op_executor: RTL

//  Sequential execute stage fed by the 4-bit operation-select lines of the op-decode stage.

---
 rtl/op_exec_pkg.sv | 40 ++++
 rtl/op_executor_shift_add_mul.sv | 60 ++++++
 rtl/op_executor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/op_exec_pkg.sv
// Shared types and constants for the op_executor execute stage.
//   state_t : top-level FSM states
//   op_t    : operation resolved from the decode-stage select lines
//   SEL_*   : bit positions of each operation in the 4-bit select word
//   resolve_op() : fixed-priority select decode (ADD > MUL > SUB > AND, zero -> ERR)
package op_exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_MUL = 3'd3,
        OP_ERR = 3'd4
    } op_t;

    localparam int SEL_ADD = 3;
    localparam int SEL_AND = 2;
    localparam int SEL_SUB = 1;
    localparam int SEL_MUL = 0;

    // The decode stage may drive several lines at once; the highest
    // priority line wins.
    function automatic op_t resolve_op(input logic [3:0] s);
        op_t r;
        if (s[SEL_ADD])      r = OP_ADD;
        else if (s[SEL_MUL]) r = OP_MUL;
        else if (s[SEL_SUB]) r = OP_SUB;
        else if (s[SEL_AND]) r = OP_AND;
        else                 r = OP_ERR;
        return r;
    endfunction

endpackage

// File: rtl/op_executor_shift_add_mul.sv
// Iterative shift-add multiplier, one partial product per step.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture a (multiplicand) and b (multiplier), clear state
//   step      : perform one iteration
//   a, b      : W-bit unsigned operands
//   product   : 2*W-bit accumulator
//   last      : the next step is the W-th (final) iteration
//   done      : set once all W iterations have been applied, cleared by load
module shift_add_mul
    import op_exec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last,
    output logic           done
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign last = (cnt == CW'(W - 1)) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else if (load) begin
            product <= '0;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            done    <= 1'b0;
        end else if (step && !done) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/op_executor.sv
// Sequential execute stage between op-decode and the result register.
// Optional feature: define OP_EXECUTOR_OVF_EN to add the ovf output.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, sampled only in IDLE
//   sel       : 4-bit op-select lines (multi-hot, fixed priority)
//   a, b      : W-bit unsigned operands
//   busy      : high from capture until done
//   done      : one-cycle pulse, result valid
//   err       : one-cycle flag with done when sel was all-zero
//   result    : 2*W-bit registered result, held until the next write
//   ovf       : (OP_EXECUTOR_OVF_EN only) ADD carry / SUB borrow, valid with done
//
// state | meaning
// IDLE  | waiting for start; operands and op captured on start
// EXEC  | single-cycle ADD/SUB/AND/ERR, writes result and pulses done
// MUL   | shift-add multiplier iterating, one bit per cycle
// FIN   | multiplier finished, writes product and pulses done
module op_executor
    import op_exec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     sel,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] result
`ifdef OP_EXECUTOR_OVF_EN
    ,
    output logic           ovf
`endif
);

    state_t         state;
    op_t            op_q;
    op_t            cap_op;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] add_full;
    logic [W-1:0]   sub_w;
    logic           mul_load;
    logic           mul_step;
    logic [2*W-1:0] mul_product;
    logic           mul_last;
    logic           mul_done;

    assign cap_op   = resolve_op(sel);
    assign add_full = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
    assign sub_w    = a_q - b_q;

    // The multiplier takes operands straight from the inputs on the capture
    // edge so its first iteration lines up with the first MUL cycle.
    assign mul_load = (state == IDLE) && start;
    assign mul_step = (state == MUL) && !mul_done;

    shift_add_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .last    (mul_last),
        .done    (mul_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ERR;
            a_q    <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
`ifdef OP_EXECUTOR_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef OP_EXECUTOR_OVF_EN
            ovf  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= cap_op;
                        busy  <= 1'b1;
                        state <= (cap_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            result <= add_full;
`ifdef OP_EXECUTOR_OVF_EN
                            ovf    <= add_full[W];
`endif
                        end
                        OP_SUB: begin
                            result <= {{W{1'b0}}, sub_w};
`ifdef OP_EXECUTOR_OVF_EN
                            ovf    <= (a_q < b_q);
`endif
                        end
                        OP_AND: begin
                            result <= {{W{1'b0}}, a_q & b_q};
                        end
                        default: begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                MUL: begin
                    if (mul_last) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result <= mul_product;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
